// File: rtl/bus_master_if_pkg.sv
// rtl/bus_master_if_pkg.sv - shared bus master state, direction and signal-level definitions
package bus_master_if_pkg;

  // Bus interface controller states
  typedef enum logic [1:0] {
    BUS_IF_STATE_IDLE   = 2'd0,
    BUS_IF_STATE_REQ    = 2'd1,
    BUS_IF_STATE_ACCESS = 2'd2,
    BUS_IF_STATE_STALL  = 2'd3
  } bus_if_state_e;

  // Bus direction encoding
  localparam logic BUS_READ  = 1'b1;
  localparam logic BUS_WRITE = 1'b0;

  // Levels for the active-low bus handshake signals
  localparam logic BUS_ENABLE_N  = 1'b0;
  localparam logic BUS_DISABLE_N = 1'b1;

  // Default number of ACCESS cycles to wait for a slave before aborting
  localparam int BUS_DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/bus_master_if.sv
// rtl/bus_master_if.sv - per-master request/grant/strobe/ready controller with ready watchdog
module bus_master_if
  import bus_master_if_pkg::*;
#(
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = BUS_DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_rw,
  input  logic [DATA_W-1:0] if_wr_data,
  output logic [DATA_W-1:0] if_rd_data,
  output logic              busy,
  output logic              bus_err,
  output logic              bus_req_,
  input  logic              bus_grnt_,
  output logic              bus_as_,
  output logic              bus_rw,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wr_data,
  input  logic [DATA_W-1:0] bus_rd_data,
  input  logic              bus_rdy_
);

  localparam int WDT_W = $clog2(TIMEOUT);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(TIMEOUT - 1);

  bus_if_state_e     state_q;
  logic [WDT_W-1:0]  wdt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rw_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rd_buf_q;
  logic              bus_req_q;
  logic              bus_as_q;
  logic              bus_rw_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [DATA_W-1:0] bus_wr_data_q;
  logic              bus_err_q;

  logic in_access;
  logic rdy_seen;
  logic wdt_expired;
  logic is_read;

  assign in_access   = (state_q == BUS_IF_STATE_ACCESS);
  assign rdy_seen    = in_access && (bus_rdy_ == BUS_ENABLE_N);
  assign wdt_expired = in_access && (bus_rdy_ == BUS_DISABLE_N) && (wdt_q == WDT_LAST);
  assign is_read     = (rw_q != BUS_WRITE);

  assign bus_req_    = bus_req_q;
  assign bus_as_     = bus_as_q;
  assign bus_rw      = bus_rw_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wr_data = bus_wr_data_q;
  assign bus_err     = bus_err_q;

  // Stage-facing stall and read data; ready data bypasses the buffer in its own cycle
  always_comb begin
    busy       = 1'b0;
    if_rd_data = rd_buf_q;
    case (state_q)
      BUS_IF_STATE_IDLE:   busy = if_req & ~flush;
      BUS_IF_STATE_REQ:    busy = 1'b1;
      BUS_IF_STATE_ACCESS: begin
        busy = ~(rdy_seen | wdt_expired);
        if (rdy_seen && is_read) begin
          if_rd_data = bus_rd_data;
        end
      end
      default:             busy = 1'b0;
    endcase
  end

  // Access sequencer: state, latched request, registered bus outputs and watchdog
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= BUS_IF_STATE_IDLE;
      wdt_q         <= '0;
      addr_q        <= '0;
      rw_q          <= BUS_READ;
      wdata_q       <= '0;
      rd_buf_q      <= '0;
      bus_req_q     <= BUS_DISABLE_N;
      bus_as_q      <= BUS_DISABLE_N;
      bus_rw_q      <= BUS_READ;
      bus_addr_q    <= '0;
      bus_wr_data_q <= '0;
      bus_err_q     <= 1'b0;
    end else begin
      bus_err_q <= 1'b0;
      case (state_q)
        BUS_IF_STATE_IDLE: begin
          if (if_req && !flush) begin
            addr_q    <= if_addr;
            rw_q      <= if_rw;
            wdata_q   <= if_wr_data;
            bus_req_q <= BUS_ENABLE_N;
            state_q   <= BUS_IF_STATE_REQ;
          end
        end
        BUS_IF_STATE_REQ: begin
          // A flush cancels the request even when the grant arrives in the same cycle
          if (flush) begin
            bus_req_q <= BUS_DISABLE_N;
            state_q   <= BUS_IF_STATE_IDLE;
          end else if (bus_grnt_ == BUS_ENABLE_N) begin
            bus_as_q      <= BUS_ENABLE_N;
            bus_addr_q    <= addr_q;
            bus_rw_q      <= rw_q;
            bus_wr_data_q <= wdata_q;
            wdt_q         <= '0;
            state_q       <= BUS_IF_STATE_ACCESS;
          end
        end
        BUS_IF_STATE_ACCESS: begin
          // Strobe lasts only the first ACCESS cycle
          bus_as_q <= BUS_DISABLE_N;
          if (rdy_seen || wdt_expired) begin
            bus_req_q <= BUS_DISABLE_N;
            state_q   <= stall ? BUS_IF_STATE_STALL : BUS_IF_STATE_IDLE;
            if (wdt_expired) begin
              bus_err_q <= 1'b1;
              rd_buf_q  <= '0;
            end else if (is_read) begin
              rd_buf_q <= bus_rd_data;
            end
          end else begin
            wdt_q <= wdt_q + 1'b1;
          end
        end
        BUS_IF_STATE_STALL: begin
          if (!stall) begin
            state_q <= BUS_IF_STATE_IDLE;
          end
        end
        default: state_q <= BUS_IF_STATE_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_master_if.sv
// tb/tb_bus_master_if.sv - randomized transaction-level self-checking bench for bus_master_if
module tb_bus_master_if;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        if_req;
  logic [29:0] if_addr;
  logic        if_rw;
  logic [31:0] if_wr_data;
  logic [31:0] if_rd_data;
  logic        busy;
  logic        bus_err;
  logic        bus_req_;
  logic        bus_grnt_;
  logic        bus_as_;
  logic        bus_rw;
  logic [29:0] bus_addr;
  logic [31:0] bus_wr_data;
  logic [31:0] bus_rd_data;
  logic        bus_rdy_;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] rdbuf_m;

  bus_master_if #(
    .ADDR_W (30),
    .DATA_W (32),
    .TIMEOUT(TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .flush      (flush),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_rw      (if_rw),
    .if_wr_data (if_wr_data),
    .if_rd_data (if_rd_data),
    .busy       (busy),
    .bus_err    (bus_err),
    .bus_req_   (bus_req_),
    .bus_grnt_  (bus_grnt_),
    .bus_as_    (bus_as_),
    .bus_rw     (bus_rw),
    .bus_addr   (bus_addr),
    .bus_wr_data(bus_wr_data),
    .bus_rd_data(bus_rd_data),
    .bus_rdy_   (bus_rdy_)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values();
    chk("rst_req", 32'(bus_req_), 1);
    chk("rst_as", 32'(bus_as_), 1);
    chk("rst_rw", 32'(bus_rw), 1);
    chk("rst_addr", 32'(bus_addr), 0);
    chk("rst_wdata", bus_wr_data, 0);
    chk("rst_err", 32'(bus_err), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rdata", if_rd_data, 0);
  endtask

  // One stage access; gdel = REQ cycles before grant, rdel = ACCESS cycle index of ready
  // (>= TO means the slave never answers), nstall = stall cycles starting at completion,
  // flush_req = REQ cycle index carrying a flush (-1 none), flush_acc = random flush in ACCESS
  task automatic run_txn(input logic rw, input logic [29:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd, input int gdel, input int rdel,
                         input int nstall, input int flush_req, input bit flush_acc);
    bit aborted;
    aborted = 1'b0;
    if_req = 1'b1; if_rw = rw; if_addr = addr; if_wr_data = wd;
    flush = 1'b0; stall = 1'b0; bus_grnt_ = 1'b1; bus_rdy_ = 1'b1;
    @(negedge clk);
    chk("req_busy", 32'(busy), 1);
    chk("req_idle_req", 32'(bus_req_), 1);
    chk("req_err", 32'(bus_err), 0);
    step();
    if_req = 1'b0; if_rw = 1'($urandom); if_addr = 30'($urandom); if_wr_data = $urandom;

    for (int k = 0; k <= gdel; k++) begin
      bus_grnt_ = (k >= gdel) ? 1'b0 : 1'b1;
      flush = (k == flush_req);
      @(negedge clk);
      chk("reqst_busy", 32'(busy), 1);
      chk("reqst_req", 32'(bus_req_), 0);
      chk("reqst_as", 32'(bus_as_), 1);
      step();
      if (k == flush_req) begin
        flush = 1'b0; bus_grnt_ = 1'b1;
        @(negedge clk);
        chk("flush_req", 32'(bus_req_), 1);
        chk("flush_as", 32'(bus_as_), 1);
        chk("flush_busy", 32'(busy), 0);
        step();
        return;
      end
    end

    for (int k = 0; k < TO; k++) begin
      bit last;
      flush = flush_acc ? 1'($urandom) : 1'b0;
      bus_rdy_ = (k == rdel) ? 1'b0 : 1'b1;
      bus_rd_data = (k == rdel) ? rd : $urandom;
      last = (k == rdel) || (k == TO - 1);
      stall = last && (nstall > 0);
      @(negedge clk);
      chk("acc_as", 32'(bus_as_), (k == 0) ? 0 : 1);
      chk("acc_req", 32'(bus_req_), 0);
      chk("acc_addr", 32'(bus_addr), 32'(addr));
      chk("acc_rw", 32'(bus_rw), 32'(rw));
      chk("acc_wdata", bus_wr_data, wd);
      if (k == rdel) begin
        chk("done_busy", 32'(busy), 0);
        chk("done_rdata", if_rd_data, rw ? rd : rdbuf_m);
      end else if (k == TO - 1) begin
        chk("abort_busy", 32'(busy), 0);
        chk("abort_rdata", if_rd_data, rdbuf_m);
        aborted = 1'b1;
      end else begin
        chk("wait_busy", 32'(busy), 1);
      end
      step();
      if (last) break;
    end
    if (aborted) rdbuf_m = 32'h0;
    else if (rw) rdbuf_m = rd;
    bus_rdy_ = 1'b1; flush = 1'b0; bus_grnt_ = 1'b1;

    if (nstall > 0) begin
      for (int s = 0; s < nstall; s++) begin
        stall = (s < nstall - 1);
        if_req = 1'b1; if_rw = 1'($urandom); if_addr = 30'($urandom);
        @(negedge clk);
        chk("stall_busy", 32'(busy), 0);
        chk("stall_rdata", if_rd_data, rdbuf_m);
        chk("stall_req", 32'(bus_req_), 1);
        chk("stall_err", 32'(bus_err), (s == 0 && aborted) ? 1 : 0);
        step();
      end
      if_req = 1'b0; stall = 1'b0;
    end else begin
      @(negedge clk);
      chk("post_req", 32'(bus_req_), 1);
      chk("post_as", 32'(bus_as_), 1);
      chk("post_err", 32'(bus_err), aborted ? 1 : 0);
      chk("post_rdata", if_rd_data, rdbuf_m);
      chk("post_busy", 32'(busy), 0);
      step();
    end
  endtask

  task automatic flush_at_request();
    if_req = 1'b1; flush = 1'b1; if_addr = 30'($urandom);
    @(negedge clk);
    chk("fl0_busy", 32'(busy), 0);
    step();
    if_req = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("fl0_req", 32'(bus_req_), 1);
    chk("fl0_busy_after", 32'(busy), 0);
    step();
  endtask

  task automatic reset_mid_access();
    if_req = 1'b1; if_rw = 1'b0; if_addr = 30'h3ABCDEF; if_wr_data = 32'hA5A5A5A5;
    bus_grnt_ = 1'b1; bus_rdy_ = 1'b1;
    step();
    if_req = 1'b0; bus_grnt_ = 1'b0;
    step();
    step();
    step();
    @(negedge clk);
    chk("pre_rst_req", 32'(bus_req_), 0);
    reset = 1'b1;
    step();
    reset = 1'b0; bus_grnt_ = 1'b1;
    rdbuf_m = 32'h0;
    @(negedge clk);
    check_reset_values();
    step();
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; if_req = 1'b0; if_rw = 1'b1;
    if_addr = '0; if_wr_data = '0; bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; bus_rd_data = '0;
    rdbuf_m = 32'h0;
    step();
    step();
    reset = 1'b0;
    @(negedge clk);
    check_reset_values();
    step();

    run_txn(1'b1, 30'h0000040, 32'h0, 32'hDEADBEEF, 0, 1, 0, -1, 1'b0);
    run_txn(1'b0, 30'h0000100, 32'h12345678, 32'h0BADF00D, 4, 3, 0, -1, 1'b0);
    run_txn(1'b1, 30'h0000200, 32'h0, 32'hCAFEF00D, 1, 2, 3, -1, 1'b0);
    run_txn(1'b1, 30'h0000300, 32'h0, 32'h11111111, 0, 0, 0, 0, 1'b0);
    run_txn(1'b1, 30'h0000304, 32'h0, 32'h22222222, 2, 4, 0, -1, 1'b1);
    run_txn(1'b1, 30'h0000308, 32'h0, 32'h33333333, 0, 0, 0, -1, 1'b0);
    run_txn(1'b1, 30'h0000400, 32'h0, 32'h44444444, 1, TO + 5, 0, -1, 1'b0);
    run_txn(1'b1, 30'h0000404, 32'h0, 32'h55555555, 0, TO - 1, 2, -1, 1'b0);
    flush_at_request();

    for (int i = 0; i < 40; i++) begin
      int gdel, rdel, nst, frq;
      gdel = $urandom_range(0, 4);
      rdel = ($urandom_range(0, 5) == 0) ? TO + 3 : $urandom_range(0, 6);
      nst  = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
      frq  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, gdel) : -1;
      run_txn(1'($urandom), 30'($urandom), $urandom, $urandom, gdel, rdel, nst, frq,
              1'($urandom));
      if ($urandom_range(0, 9) == 0) flush_at_request();
    end

    reset_mid_access();
    run_txn(1'b1, 30'h0000500, 32'h0, 32'h66666666, 0, 1, 0, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
